div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL take parameter: BIT_WIDTH, default 32, operand/result width (rv32ima_pkg value).
REQ-002 The block SHALL use a single clock with a synchronous, active-high reset.
REQ-003 The block SHALL provide these ports:
  clk        in   1          rising-edge clock
  rst        in   1          synchronous active-high reset
  flush      in   1          abort current operation (pipeline flush)
  in_valid   in   1          request valid
  in_ready   out  1          unit can accept a request
  div_op     in   2          00 DIV, 01 DIVU, 10 REM, 11 REMU
  in1        in   BIT_WIDTH  dividend (rs1)
  in2        in   BIT_WIDTH  divisor (rs2)
  out_valid  out  1          result valid
  out_ready  in   1          consumer accepts result
  out        out  BIT_WIDTH  quotient or remainder per latched div_op
  div_zero   out  1          latched result came from divisor == 0

Function
REQ-004 The block SHALL implement states IDLE, CALC and DONE.
REQ-005 In_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-006 Accept SHALL occur when in_valid && in_ready at a rising edge; div_op, in1 and in2 SHALL be latched at that edge and inputs ignored afterward.
REQ-007 On accept with in2 == 0, the next state SHALL be DONE with div_zero = 1. Quotient SHALL be all ones for DIV and DIVU. Remainder SHALL be in1 for REM and REMU.
REQ-008 On accept of signed op with in1 == 0x80000000 and in2 == 0xFFFFFFFF, the next state SHALL be DONE with div_zero = 0. Quotient SHALL be 0x80000000; remainder SHALL be 0.
REQ-009 Otherwise accept SHALL enter CALC with:
  - |in1| and |in2| latched for signed ops, or raw values for unsigned ops;
  - quotient-negate flag = signed op && (in1 MSB != in2 MSB);
  - remainder-negate flag = signed op && in1 MSB.
REQ-010 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first, using a BIT_WIDTH+1-bit partial remainder; an iteration counter SHALL count BIT_WIDTH cycles.
REQ-011 After the BIT_WIDTH-th CALC cycle the state SHALL go to DONE. The selected result SHALL be two's-complement negated if its negate flag is set (mod 2^BIT_WIDTH) and registered into out.
REQ-012 Latency SHALL be as follows, with the accept cycle as cycle 0:
  - normal case: out_valid first high in cycle BIT_WIDTH+1 (33);
  - special cases (REQ-007/008): out_valid first high in cycle 1.
REQ-013 In DONE, out and div_zero SHALL hold stable while out_ready = 0.
REQ-014 A DONE cycle with out_ready = 1 SHALL return the state to IDLE next cycle.
REQ-015 No new request SHALL be accepted in the same cycle as a result handshake; back-to-back throughput is one op per BIT_WIDTH+2 cycles.
REQ-016 Flush asserted in any state SHALL return the state to IDLE at the next edge:
  - out_valid SHALL be 0 from the next cycle;
  - the in-flight result SHALL be discarded;
  - flush SHALL take priority over accept and over the result handshake.
REQ-017 Out SHALL hold the last registered result outside DONE; consumers SHALL qualify it with out_valid.
REQ-018 Div_zero SHALL clear on every accept that is not a divide-by-zero.

Reset
REQ-019 When rst = 1 at an edge, the block SHALL set state = IDLE, out = 0, div_zero = 0, out_valid = 0, counter = 0 and all internal operand/flag registers = 0.
REQ-020 Rst SHALL take priority over flush and all handshakes, including mid-CALC and in DONE.
REQ-021 In_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-022 The bench SHALL check DIVU 100 / 7 -> out_valid in cycle 33, out = 14. REMU on the same operands -> out = 2.
REQ-023 The bench SHALL check DIV 0xFFFFFFF9 (-7) / 2 -> out = 0xFFFFFFFD (-3). REM on the same operands -> out = 0xFFFFFFFF (-1).
REQ-024 The bench SHALL check DIV 5 / 0 -> out_valid in cycle 1, out = 0xFFFFFFFF, div_zero = 1. REMU 5 / 0 -> out = 5.
REQ-025 The bench SHALL check DIV 0x80000000 / 0xFFFFFFFF -> cycle 1, out = 0x80000000. REM on the same operands -> out = 0.
REQ-026 The bench SHALL check that holding out_ready = 0 for 10 cycles in DONE keeps out stable and in_ready = 0. Then out_ready = 1 -> IDLE next cycle and in_ready = 1.
REQ-027 The bench SHALL check that flush at CALC cycle 10, and separately rst at CALC cycle 10, give IDLE next cycle with out_valid = 0. A new DIVU 9 / 3 then returns 3.

Source files
------------

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed-overflow results produced in a single cycle.
module div_unit #(
   parameter int BIT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           div_op,
   input  logic [BIT_WIDTH-1:0] in1,
   input  logic [BIT_WIDTH-1:0] in2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] out,
   output logic                 div_zero
);

   localparam int CW = $clog2(BIT_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state_q;
   logic [1:0]           op_q;
   logic [BIT_WIDTH-1:0] dq_q;     // dividend bits shift out the top, quotient bits shift in
   logic [BIT_WIDTH-1:0] dvs_q;
   logic [BIT_WIDTH-1:0] rem_q;
   logic [BIT_WIDTH-1:0] out_q;
   logic [CW-1:0]        cnt_q;
   logic                 negq_q;
   logic                 negr_q;
   logic                 dz_q;

   logic                 sgn_w;
   logic                 ovf_w;
   logic [BIT_WIDTH-1:0] a_abs_w;
   logic [BIT_WIDTH-1:0] b_abs_w;
   logic [BIT_WIDTH:0]   shift_w;
   logic [BIT_WIDTH:0]   diff_w;
   logic                 qbit_w;
   logic [BIT_WIDTH-1:0] rem_d;
   logic [BIT_WIDTH-1:0] dq_d;
   logic [BIT_WIDTH-1:0] res_w;
   logic                 neg_w;
   logic [BIT_WIDTH-1:0] fin_w;

   always_comb begin
      sgn_w   = ~div_op[0];
      ovf_w   = sgn_w && (in1 == {1'b1, {(BIT_WIDTH-1){1'b0}}}) && (&in2);
      a_abs_w = (sgn_w && in1[BIT_WIDTH-1]) ? -in1 : in1;
      b_abs_w = (sgn_w && in2[BIT_WIDTH-1]) ? -in2 : in2;

      // Partial remainder is BIT_WIDTH+1 wide; a borrow out of the trial
      // subtraction shows up in its top bit and means "restore".
      shift_w = {rem_q, dq_q[BIT_WIDTH-1]};
      diff_w  = shift_w - {1'b0, dvs_q};
      qbit_w  = ~diff_w[BIT_WIDTH];
      rem_d   = qbit_w ? diff_w[BIT_WIDTH-1:0] : shift_w[BIT_WIDTH-1:0];
      dq_d    = {dq_q[BIT_WIDTH-2:0], qbit_w};

      res_w   = op_q[1] ? rem_d : dq_d;
      neg_w   = op_q[1] ? negr_q : negq_q;
      fin_w   = neg_w ? -res_w : res_w;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out       = out_q;
   assign div_zero  = dz_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         dq_q    <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else if (flush) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_q <= div_op;
                  if (in2 == '0) begin
                     out_q   <= div_op[1] ? in1 : '1;
                     dz_q    <= 1'b1;
                     state_q <= DONE;
                  end else if (ovf_w) begin
                     out_q   <= div_op[1] ? '0 : in1;
                     dz_q    <= 1'b0;
                     state_q <= DONE;
                  end else begin
                     dz_q    <= 1'b0;
                     dq_q    <= a_abs_w;
                     dvs_q   <= b_abs_w;
                     rem_q   <= '0;
                     cnt_q   <= '0;
                     negq_q  <= sgn_w && (in1[BIT_WIDTH-1] != in2[BIT_WIDTH-1]);
                     negr_q  <= sgn_w && in1[BIT_WIDTH-1];
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_d;
               dq_q  <= dq_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(BIT_WIDTH - 1)) begin
                  out_q   <= fin_w;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor
// pops and compares value, div_zero and first-valid cycle on each handshake.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  div_op;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        div_zero;

   div_unit #(.BIT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .div_op(div_op), .in1(in1), .in2(in2), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain RISC-V M-extension division semantics.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int acc);
      exp_t e;
      logic sgn;
      sgn = ~op[0];
      e.dz = 1'b0;
      e.cyc = acc + 1;
      if (b == 32'd0) begin
         e.res = op[1] ? a : 32'hFFFF_FFFF;
         e.dz  = 1'b1;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res = op[1] ? 32'd0 : 32'h8000_0000;
      end else begin
         e.cyc = acc + 33;
         if (sgn) e.res = op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
         else     e.res = op[1] ? a % b : a / b;
      end
      return e;
   endfunction

   // Monitor: compares on each result handshake.
   logic pv = 1'b0;
   int   first = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         pv = 1'b0;
      end else begin
         if (out_valid && !pv) first = cyc;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_result: got %h expected none", out);
            end else begin
               e = q.pop_front();
               chk("result", out, e.res);
               chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
               chk("latency_cycle", first, e.cyc);
            end
         end
         pv = out_valid;
      end
   end

   // Issue one op; optionally push an expected item and wait for it to drain.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic dz, input int lat,
                        input bit push, input bit drain);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      in_valid = 1'b1; div_op = op; in1 = a; in2 = b;
      if (push) begin
         e.res = res; e.dz = dz; e.cyc = cyc + lat;
         q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; div_op = 2'($urandom); in1 = $urandom; in2 = $urandom;
      if (drain) begin
         n = 0;
         while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
         if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
         end
      end
   endtask

   task automatic op_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t m;
      m = model(op, a, b, 0);
      do_op(op, a, b, m.res, m.dz, m.cyc, 1'b1, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit seen;
      logic [1:0]  op;
      logic [31:0] a, b;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; div_op = 2'd0;
      in1 = '0; in2 = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out", out, 32'd0);
      chk("reset_div_zero", {31'd0, div_zero}, 32'd0);

      // Directed cases
      do_op(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b1, 1'b1);
      do_op(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1'b1, 1'b1);
      do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 1'b1, 1'b1);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 1'b1, 1'b1);
      do_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 1'b1, 1'b1);
      do_op(2'b11, 32'd5, 32'd0, 32'd5, 1'b1, 1, 1'b1, 1'b1);
      do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1'b1, 1'b1);
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 1'b1, 1'b1);

      // Backpressure: result must hold for 10 cycles with out_ready low
      out_ready = 1'b0;
      do_op(2'b01, 32'd1000, 32'd10, 32'd100, 1'b0, 33, 1'b1, 1'b0);
      n = 0;
      while (!out_valid && n < 60) begin @(negedge clk); n++; end
      chk("hold_reached_done", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         chk("hold_out", out, 32'd100);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         @(negedge clk);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("release_out_valid", {31'd0, out_valid}, 32'd0);
      chk("release_queue_empty", q.size(), 32'd0);

      // Flush at CALC cycle 10
      do_op(2'b01, 32'd123456, 32'd7, 32'd0, 1'b0, 0, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      chk("calc10_in_ready", {31'd0, in_ready}, 32'd0);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_out_held", out, 32'd100);
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      chk("flush_discarded", {31'd0, seen}, 32'd0);
      do_op(2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 33, 1'b1, 1'b1);

      // Reset at CALC cycle 10
      do_op(2'b00, 32'hFFFF_0000, 32'd5, 32'd0, 1'b0, 0, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1; flush = 1'b1;
      @(posedge clk); #1 rst = 1'b0; flush = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out", out, 32'd0);
      chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
      do_op(2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 33, 1'b1, 1'b1);

      // Randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 9))
            0:       b = 32'd0;
            1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2:       b = 32'($urandom_range(1, 15));
            3:       b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         op_model(op, a, b);
      end

      repeat (5) @(negedge clk);
      chk("final_queue_empty", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
